// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring divider, one quotient bit per cycle.
//               Signed mode is built in only when SEQ_DIVIDER_SIGNED_EN is
//               defined; otherwise signed_op is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div0
);

    localparam int             c_CW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [N-1:0]    r_dvd;
    logic [N-1:0]    r_dvs;
    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_quo;
    logic            r_zero;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_r;
    logic            r_div0;
    logic            r_neg_q;
    logic            r_neg_r;

    logic [N-1:0]    w_dvd_mag;
    logic [N-1:0]    w_dvs_mag;
    logic            w_neg_q;
    logic            w_neg_r;
    logic [N-1:0]    w_q_fin;
    logic [N-1:0]    w_r_fin;
    logic [N:0]      w_shift;
    logic            w_ge;
    logic [N-1:0]    w_sub;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign w_neg_r   = signed_op & dividend[N-1];
    assign w_neg_q   = signed_op & (dividend[N-1] ^ divisor[N-1]);
    assign w_dvd_mag = w_neg_r ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = (signed_op & divisor[N-1]) ? (~divisor + 1'b1) : divisor;
    assign w_q_fin   = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fin   = r_neg_r ? (~r_rem + 1'b1) : r_rem;
`else
    logic w_unused_signed;
    assign w_unused_signed = signed_op;
    assign w_neg_r   = 1'b0;
    assign w_neg_q   = 1'b0;
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_fin   = r_quo;
    assign w_r_fin   = r_rem;
`endif

    // Shifted remainder is one bit wider so the compare never overflows;
    // when it wins, the difference is below the divisor and fits in N bits.
    assign w_shift = {r_rem, r_dvd[N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[N-1:0] - r_dvs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_div0  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_dvs  <= w_dvs_mag;
                        if (divisor == '0) begin
                            // Divide-by-zero skips iteration; the raw dividend
                            // is reported unchanged as the remainder.
                            r_state <= c_DONE;
                            r_zero  <= 1'b1;
                            r_quo   <= '1;
                            r_rem   <= dividend;
                            r_dvd   <= dividend;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_state <= c_CALC;
                            r_zero  <= 1'b0;
                            r_quo   <= '0;
                            r_rem   <= '0;
                            r_dvd   <= w_dvd_mag;
                            r_neg_q <= w_neg_q;
                            r_neg_r <= w_neg_r;
                        end
                    end
                end
                c_CALC: begin
                    r_rem <= w_ge ? w_sub : w_shift[N-1:0];
                    r_quo <= {r_quo[N-2:0], w_ge};
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_q     <= w_q_fin;
                    r_r     <= w_r_fin;
                    r_div0  <= r_zero;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_r;
    assign div0      = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider; expectations
//               follow SEQ_DIVIDER_SIGNED_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N     = 16;
    localparam int c_NV  = 10;
    localparam int c_MAX = 40;

    typedef struct {
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic         sgn;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div0;

    int checks = 0;
    int errors = 0;
    vec_t vecs [c_NV];

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation and check latency, busy profile and results.
    // Returns #1 after the edge that raised done, so a following call
    // issues its start in the done cycle.
    task automatic run_op(input string name, input vec_t v);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        dividend  = v.dvd;
        divisor   = v.dvs;
        signed_op = v.sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'h0003;
        lat      = 0;
        seen     = 1'b0;
        busy_ok  = (busy === 1'b1) && (done === 1'b0);
        while (!seen && lat < c_MAX) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) begin
                seen = 1'b1;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        chk({name, "_done"}, 32'(seen), 32'd1);
        chk({name, "_lat"}, lat, v.lat);
        chk({name, "_busy"}, 32'(busy_ok), 32'd1);
        chk({name, "_q"}, 32'(quotient), 32'(v.q));
        chk({name, "_r"}, 32'(remainder), 32'(v.r));
        chk({name, "_div0"}, 32'(div0), 32'(v.z));
    endtask

    initial begin
        int ndone;
        int first_lat;

        vecs[0] = '{16'd100,   16'd7,     1'b0, 16'd14,    16'd2,    1'b0, 17};
        vecs[1] = '{16'd5,     16'd0,     1'b0, 16'hFFFF,  16'h0005, 1'b1, 1};
        vecs[2] = '{16'hFFFF,  16'h0001,  1'b0, 16'hFFFF,  16'h0000, 1'b0, 17};
        vecs[3] = '{16'hFFFF,  16'hFFFF,  1'b0, 16'h0001,  16'h0000, 1'b0, 17};
        vecs[4] = '{16'd7,     16'd100,   1'b0, 16'h0000,  16'h0007, 1'b0, 17};
        vecs[5] = '{16'h1234,  16'h0010,  1'b0, 16'h0123,  16'h0004, 1'b0, 17};
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[6] = '{16'hFF9C,  16'd7,     1'b1, 16'hFFF2,  16'hFFFE, 1'b0, 17};
        vecs[7] = '{16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'h0000, 1'b0, 17};
        vecs[8] = '{16'd100,   16'hFFF9,  1'b1, 16'hFFF2,  16'h0002, 1'b0, 17};
        vecs[9] = '{16'hFF9C,  16'hFFF9,  1'b1, 16'h000E,  16'hFFFE, 1'b0, 17};
`else
        vecs[6] = '{16'hFF9C,  16'd7,     1'b1, 16'h2484,  16'h0000, 1'b0, 17};
        vecs[7] = '{16'h8000,  16'hFFFF,  1'b1, 16'h0000,  16'h8000, 1'b0, 17};
        vecs[8] = '{16'd100,   16'hFFF9,  1'b1, 16'h0000,  16'h0064, 1'b0, 17};
        vecs[9] = '{16'hFF9C,  16'hFFF9,  1'b1, 16'h0000,  16'hFF9C, 1'b0, 17};
`endif

        // Power-up reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table
        for (int i = 0; i < c_NV; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // done is a single pulse and results are held afterwards
        @(posedge clk);
        #1;
        chk("pulse_done", 32'(done), 32'd0);
        chk("hold_q", 32'(quotient), 32'(vecs[c_NV-1].q));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_r", 32'(remainder), 32'(vecs[c_NV-1].r));

        // Start re-pulsed at edge 5 with other operands is ignored
        @(negedge clk);
        dividend  = 16'd100;
        divisor   = 16'd7;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ndone     = 0;
        first_lat = 0;
        for (int e = 6; e <= c_MAX; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first_lat == 0) first_lat = e;
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", first_lat, 17);
        chk("ign_q", 32'(quotient), 32'd14);
        chk("ign_r", 32'(remainder), 32'd2);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        dividend = 16'd300;
        divisor  = 16'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_q", 32'(quotient), 32'd0);
        chk("arst_r", 32'(remainder), 32'd0);
        chk("arst_div0", 32'(div0), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        run_op("post_rst", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
